input_controller: RTL and testbench
===================================

# input_controller

Debounces the three raw push-buttons (left, right, start) and publishes their state as one memory-mapped status word in the shared dual-port RAM, so the CPU reads the controls with an ordinary load. Sits upstream of the RAM on port A and uses the cycles in which the VGA position fetcher's slot counter selects an unused mux input. Only RAM port A is driven; the CPU's port B is untouched.

## Interface
- WIDTH, 16, RAM data/address width
- DEBOUNCE_BITS, 16, debounce counter width; a change must persist 2^DEBOUNCE_BITS-1 cycles
- INPUT_ADDR, 16'd6024, RAM address of the status word
- WRITE_SLOT, 3'd6, vga_counter value whose cycle this block owns on port A

- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- left  in  1  raw button, active-low (pressed = 0), asynchronous
- right  in  1  raw button, active-low, asynchronous
- start  in  1  raw button, active-low, asynchronous
- vga_counter  in  3  VGA fetch slot counter; increments by 1 per clk, wraps 7->0
- mem_address_a  out  WIDTH  port-A address; constant INPUT_ADDR
- data_to_mem_a  out  WIDTH  port-A write data, registered
- we_a  out  1  port-A write enable, registered; top level selects mem_address_a onto port A while high
- buttons_stable  out  3  debounced state {start,right,left}, 1 = pressed

## Operation
- Per button: 2-flop synchronizer, inverted to active-high.
- Debounce per button: synced == stable -> counter cleared; synced != stable -> counter increments; on reaching all-ones, stable <= synced and counter cleared.
- Start event flag (sticky): set on a 0->1 transition of stable start. Cleared by the write that carries it; if a new rising edge of stable start coincides with that write cycle, the flag stays set.
- Status word: bit0 left, bit1 right, bit2 start (held), bit3 start event, bits7:4 zero, bits15:8 seq = number of writes completed before this one (8-bit, wraps 255->0).
- last_written: 4-bit copy of bits3:0 of the most recent write; reset 0. dirty = (current bits3:0 != last_written).
- FSM:
  - IDLE: dirty -> ARMED.
  - ARMED: vga_counter == WRITE_SLOT-1 (mod 8) -> WRITE; load data_to_mem_a with the current word, set we_a.
  - WRITE: exactly one cycle, aligned with vga_counter == WRITE_SLOT. Clear we_a, update last_written, increment seq, clear event flag if it was written. -> ARMED if dirty again, else IDLE.
- Button changes while ARMED need no extra handling; the word is sampled at the transition into WRITE.

## Timing
- Reset values: data_to_mem_a 0, we_a 0, buttons_stable 000, seq 0, event flag 0, state IDLE, debounce counters 0, synchronizers 1 (released).
- Raw edge -> synced: 2 cycles. synced -> stable: 2^DEBOUNCE_BITS-1 further cycles of unchanged input. stable -> ARMED: 1 cycle. ARMED -> WRITE: 1 to 8 cycles.
- we_a is high for one cycle, never two in a row. At most one write per 8-cycle slot period.
- Reset asserted in any state: the next cycle is in reset values, and a pending write is dropped. If reset occurs during WRITE, we_a falls with it.
- WRITE_SLOT == 0: the arming compare uses 7.

## Configuration
- BUTTON_DEBOUNCE_EN defined: debounce counters active as above.
- Not defined: stable <= synced every cycle (2-cycle latency) and the counters are not built. Used for fast simulation; the write FSM is unchanged.

## Test plan
- Hold reset=0 for 5 cycles with buttons toggling -> we_a 0, data_to_mem_a 0x0000, buttons_stable 000 throughout.
- DEBOUNCE_BITS=4: left=0 held -> buttons_stable[0] rises 17 cycles after the edge. Exactly one we_a pulse follows, with vga_counter==6 and data 0x0001.
- DEBOUNCE_BITS=4: left toggled every 5 cycles for 100 cycles -> buttons_stable stays 000 and no we_a pulse.
- Press start, then release after debounce, both before the slot -> first write 0x0008 (event only, seq 0). After the release settles there is no further write, since bits3:0 matched last_written = 0x0. A second press writes 0x010C.
- Reset pulsed while in ARMED, one cycle before the slot -> no we_a pulse, and seq restarts at 0.
- BUTTON_DEBOUNCE_EN undefined: right=0 -> buttons_stable[1] high 2 cycles later, then a write with data 0x0002.

Source files
------------

// File: rtl/input_controller.sv
// Debounces left/right/start buttons and publishes them as a status word on RAM port A.
// Define BUTTON_DEBOUNCE_EN to build the debounce counters; otherwise stable follows the synchronizers.
module input_controller #(
    parameter int               WIDTH         = 16,
    parameter int               DEBOUNCE_BITS = 16,
    parameter logic [WIDTH-1:0] INPUT_ADDR    = 16'd6024,
    parameter logic [2:0]       WRITE_SLOT    = 3'd6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             left,
    input  logic             right,
    input  logic             start,
    input  logic [2:0]       vga_counter,
    output logic [WIDTH-1:0] mem_address_a,
    output logic [WIDTH-1:0] data_to_mem_a,
    output logic             we_a,
    output logic [2:0]       buttons_stable
);

    localparam logic [2:0] ARM_SLOT = WRITE_SLOT - 3'd1;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        WRITE
    } state_t;

    state_t state;

    logic [2:0] sync_1;
    logic [2:0] sync_2;
    logic [2:0] synced;
    logic [2:0] stable;

    assign mem_address_a = INPUT_ADDR;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_1 <= 3'b111;
            sync_2 <= 3'b111;
        end else begin
            sync_1 <= {start, right, left};
            sync_2 <= sync_1;
        end
    end

    assign synced = ~sync_2;

`ifdef BUTTON_DEBOUNCE_EN
    // Counting stops one short of all-ones so the change lands after 2^N-1 mismatched cycles.
    localparam logic [DEBOUNCE_BITS-1:0] DB_LAST = DEBOUNCE_BITS'(2 ** DEBOUNCE_BITS - 2);

    logic [DEBOUNCE_BITS-1:0] db_count [3];

    always_ff @(posedge clk) begin
        if (!reset) begin
            stable <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (synced[i] == stable[i]) begin
                    db_count[i] <= '0;
                end else if (db_count[i] == DB_LAST) begin
                    stable[i]   <= synced[i];
                    db_count[i] <= '0;
                end else begin
                    db_count[i] <= db_count[i] + DEBOUNCE_BITS'(1);
                end
            end
        end
    end
`else
    assign stable = synced;
`endif

    assign buttons_stable = stable;

    logic             start_prev;
    logic             start_event;
    logic             start_rise;
    logic             event_next;
    logic [7:0]       seq;
    logic [3:0]       last_written;
    logic [3:0]       status_bits;
    logic [WIDTH-1:0] status_word;
    logic             dirty;
    logic             dirty_after_write;

    assign start_rise  = stable[2] & ~start_prev;
    assign status_bits = {start_event, stable};

    always_comb begin
        event_next = start_event;
        if (state == WRITE && data_to_mem_a[3]) begin
            event_next = start_rise;
        end else if (start_rise) begin
            event_next = 1'b1;
        end
    end

    always_comb begin
        status_word       = '0;
        status_word[3:0]  = status_bits;
        status_word[15:8] = seq;
    end

    // The event bit is consumed by the write that carries it, so it is never remembered as written.
    assign dirty             = status_bits != last_written;
    assign dirty_after_write = {event_next, stable} != {1'b0, data_to_mem_a[2:0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            we_a          <= 1'b0;
            data_to_mem_a <= '0;
            seq           <= 8'd0;
            last_written  <= 4'd0;
            start_prev    <= 1'b0;
            start_event   <= 1'b0;
        end else begin
            start_prev  <= stable[2];
            start_event <= event_next;
            case (state)
                IDLE: begin
                    if (dirty) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (vga_counter == ARM_SLOT) begin
                        state         <= WRITE;
                        data_to_mem_a <= status_word;
                        we_a          <= 1'b1;
                    end
                end
                WRITE: begin
                    we_a         <= 1'b0;
                    last_written <= {1'b0, data_to_mem_a[2:0]};
                    seq          <= seq + 8'd1;
                    state        <= dirty_after_write ? ARMED : IDLE;
                end
                default: begin
                    state <= IDLE;
                    we_a  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_controller.sv
// Scoreboard bench for input_controller: stimulus pushes expected writes, a monitor pops them on we_a.
// Honours BUTTON_DEBOUNCE_EN for the button-to-stable latency.
module tb_input_controller;

    localparam int DB_BITS = 4;
`ifdef BUTTON_DEBOUNCE_EN
    localparam int STABLE_EDGES = 2 + (2 ** DB_BITS) - 1;
`else
    localparam int STABLE_EDGES = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        left = 1'b1;
    logic        right = 1'b1;
    logic        start = 1'b1;
    logic [2:0]  vga_counter = 3'd0;
    logic [15:0] mem_address_a;
    logic [15:0] data_to_mem_a;
    logic        we_a;
    logic [2:0]  buttons_stable;

    logic [15:0] expected_q [$];
    int          vectors = 0;
    int          miscompares = 0;
    logic        prev_we = 1'b0;

    input_controller #(
        .WIDTH         (16),
        .DEBOUNCE_BITS (DB_BITS),
        .INPUT_ADDR    (16'd6024),
        .WRITE_SLOT    (3'd6)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .left           (left),
        .right          (right),
        .start          (start),
        .vga_counter    (vga_counter),
        .mem_address_a  (mem_address_a),
        .data_to_mem_a  (data_to_mem_a),
        .we_a           (we_a),
        .buttons_stable (buttons_stable)
    );

    always #5 clk = ~clk;

    // Free-running VGA slot counter, advanced just after each rising edge.
    always @(posedge clk) begin
        #1;
        vga_counter = vga_counter + 3'd1;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    task automatic apply_stimulus(input logic l, input logic r, input logic s);
        left  = l;
        right = r;
        start = s;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_slot(input logic [2:0] v);
        int k = 0;
        while (vga_counter != v && k < 8) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic drain(input string name);
        int waited = 0;
        while (expected_q.size() != 0 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        check_output(name, expected_q.size(), 0);
        expected_q.delete();
    endtask

    always @(negedge clk) begin
        if (we_a === 1'b1) begin
            check_output("we_a_single_cycle", prev_we, 0);
            check_output("write_slot", vga_counter, 6);
            check_output("write_address", mem_address_a, 16'd6024);
            if (expected_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_write: got data 0x%0h, expected no write", data_to_mem_a);
            end else begin
                check_output("write_data", data_to_mem_a, expected_q.pop_front());
            end
        end
        prev_we = we_a;
    end

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("reset_we_a", we_a, 0);
            check_output("reset_data", data_to_mem_a, 0);
            check_output("reset_stable", buttons_stable, 0);
            apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        check_output("address_const", mem_address_a, 16'd6024);
        apply_stimulus(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        step(20);

        apply_stimulus(1'b0, 1'b1, 1'b1);
        step(STABLE_EDGES - 1);
        check_output("left_settling", buttons_stable, 3'b000);
        step(1);
        check_output("left_stable", buttons_stable, 3'b001);
        expected_q.push_back(16'h0001);
        drain("left_press_write");
        apply_stimulus(1'b1, 1'b1, 1'b1);
        expected_q.push_back(16'h0100);
        drain("left_release_write");

        apply_stimulus(1'b1, 1'b0, 1'b1);
        step(STABLE_EDGES);
        check_output("right_stable", buttons_stable, 3'b010);
        expected_q.push_back(16'h0202);
        drain("right_press_write");
        apply_stimulus(1'b1, 1'b1, 1'b1);
        expected_q.push_back(16'h0300);
        drain("right_release_write");
        step(16);

`ifdef BUTTON_DEBOUNCE_EN
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'(i % 2), 1'b1, 1'b1);
            step(5);
            check_output("bounce_stable", buttons_stable, 3'b000);
        end
        apply_stimulus(1'b1, 1'b1, 1'b1);
        step(24);
`else
        reset = 1'b0;
        step(1);
        check_output("midrun_reset_data", data_to_mem_a, 0);
        reset = 1'b1;
        step(4);
        wait_slot(3'd7);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        step(3);
        apply_stimulus(1'b1, 1'b1, 1'b1);
        expected_q.push_back(16'h0008);
        drain("start_event_write");
        step(16);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        expected_q.push_back(16'h010C);
        drain("start_second_press_write");
        apply_stimulus(1'b1, 1'b1, 1'b1);
        expected_q.push_back(16'h0200);
        drain("start_release_write");
`endif

        step(8);
        apply_stimulus(1'b0, 1'b1, 1'b1);
        step(STABLE_EDGES);
        check_output("armed_left_stable", buttons_stable, 3'b001);
        step(1);
        wait_slot(3'd5);
        reset = 1'b0;
        step(1);
        check_output("armed_reset_we_a", we_a, 0);
        check_output("armed_reset_data", data_to_mem_a, 0);
        reset = 1'b1;
        expected_q.push_back(16'h0001);
        drain("post_reset_seq_write");
        apply_stimulus(1'b1, 1'b1, 1'b1);
        expected_q.push_back(16'h0100);
        drain("post_reset_release_write");
        step(16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        miscompares++;
        $display("[TB] FAIL watchdog: got timeout, expected bench completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
